// File: rtl/weight_store_pkg.sv
// weight_store_pkg: shared sizes and FSM encoding for the weight store server.
package weight_store_pkg;
    localparam int DEPTH  = 16384;
    localparam int ADDR_W = 14;
    localparam int CSUM_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/weight_store_server_if.sv
// weight_store_server_if: host loader stream plus matvec read port of the weight store.
interface weight_store_server_if #(
    parameter int ADDR_W = weight_store_pkg::ADDR_W,
    parameter int CSUM_W = weight_store_pkg::CSUM_W
);
    logic                load_start;
    logic [ADDR_W-1:0]   load_base;
    logic [ADDR_W:0]     load_count;
    logic [7:0]          s_data;
    logic                s_valid;
    logic                s_ready;
    logic                load_busy;
    logic                load_done;
    logic                load_err;
    logic [CSUM_W-1:0]   load_csum;
    logic                weight_rd_en;
    logic [ADDR_W-1:0]   weight_addr;
    logic signed [7:0]   weight_data;
    logic                weight_valid;
    modport master (
        output load_start, load_base, load_count, s_data, s_valid, weight_rd_en, weight_addr,
        input  s_ready, load_busy, load_done, load_err, load_csum, weight_data, weight_valid
    );
    modport slave (
        input  load_start, load_base, load_count, s_data, s_valid, weight_rd_en, weight_addr,
        output s_ready, load_busy, load_done, load_err, load_csum, weight_data, weight_valid
    );
endinterface

// File: rtl/sp_bram_int8.sv
// sp_bram_int8: single-port synchronous INT8 RAM; the read register holds when not reading.
module sp_bram_int8 #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (en && we) mem[addr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout <= '0;
        else if (en && !we) dout <= mem[addr];
endmodule

// File: rtl/weight_store_server.sv
// weight_store_server: INT8 weight memory filled from a host byte stream,
// read by the matvec engines with one-cycle registered latency.
module weight_store_server #(
    parameter int DEPTH  = weight_store_pkg::DEPTH,
    parameter int ADDR_W = weight_store_pkg::ADDR_W,
    parameter int CSUM_W = weight_store_pkg::CSUM_W
) (
    input logic clk,
    input logic rst_n,
    weight_store_server_if.slave bus
);
    import weight_store_pkg::*;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, ram_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W+1:0] end_addr;
    logic start_req, start_ok, accept, rd_ok;
    // end address is one bit wider than load_count so oversize requests cannot wrap
    assign end_addr  = {2'b0, bus.load_base} + {1'b0, bus.load_count};
    assign start_req = state == IDLE && bus.load_start;
    assign start_ok  = start_req && bus.load_count != '0 && end_addr <= (ADDR_W+2)'(DEPTH);
    assign accept    = bus.s_ready && bus.s_valid;
    assign rd_ok     = bus.weight_rd_en && state != LOAD;
    assign ram_addr  = state == LOAD ? wr_addr : bus.weight_addr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE ? (start_ok ? LOAD : IDLE) :
                    state == LOAD ? (accept && remaining == 1 ? DONE : LOAD) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_addr          <= '0;
            remaining        <= '0;
            bus.s_ready      <= 1'b0;
            bus.load_busy    <= 1'b0;
            bus.load_done    <= 1'b0;
            bus.load_err     <= 1'b0;
            bus.load_csum    <= '0;
            bus.weight_valid <= 1'b0;
        end else begin
            bus.s_ready      <= state_nxt == LOAD;
            bus.load_busy    <= state_nxt == LOAD;
            bus.load_done    <= state_nxt == DONE;
            bus.weight_valid <= rd_ok;
            if (start_req) bus.load_err <= !start_ok;
            if (start_ok) begin
                wr_addr       <= bus.load_base;
                remaining     <= bus.load_count;
                bus.load_csum <= '0;
            end else if (accept) begin
                wr_addr       <= wr_addr + 1'b1;
                remaining     <= remaining - 1'b1;
                bus.load_csum <= bus.load_csum + CSUM_W'(bus.s_data);
            end
        end
    sp_bram_int8 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept || rd_ok),
        .we    (accept),
        .addr  (ram_addr),
        .din   (bus.s_data),
        .dout  (bus.weight_data)
    );
endmodule

// File: tb/tb_weight_store_server.sv
// tb_weight_store_server: directed plus random stimulus checked every cycle against a transaction-level model.
module tb_weight_store_server;
    import weight_store_pkg::*;
    logic clk, rst_n;
    int total = 0, bad = 0, done_cnt = 0;
    weight_store_server_if bus ();
    weight_store_server dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;

    logic [7:0]  mem_m [DEPTH];
    bit          known_m [DEPTH];
    int          m_rem = 0, m_addr = 0;
    logic [15:0] m_csum = 0;
    bit          m_err = 0, m_done = 0, m_wvalid = 0, m_wknown = 1;
    logic [7:0]  m_wdata = 0;

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // Model: a load is "in progress" while bytes remain; done is the cycle after the last byte lands.
    always @(posedge clk or negedge rst_n) begin : model
        bit loading, was_done;
        if (!rst_n) begin
            m_rem = 0; m_addr = 0; m_csum = 0; m_err = 0; m_done = 0;
            m_wvalid = 0; m_wdata = 0; m_wknown = 1;
        end else begin
            loading  = m_rem > 0;
            was_done = m_done;
            m_done   = 0;
            m_wvalid = bus.weight_rd_en && !loading;
            if (m_wvalid) begin
                m_wdata  = mem_m[bus.weight_addr];
                m_wknown = known_m[bus.weight_addr];
            end
            if (loading) begin
                if (bus.s_valid) begin
                    mem_m[m_addr] = bus.s_data;
                    known_m[m_addr] = 1;
                    m_addr++;
                    m_rem--;
                    m_csum = 16'((int'(m_csum) + int'(bus.s_data)) % 65536);
                    m_done = m_rem == 0;
                end
            end else if (!was_done && bus.load_start) begin
                if (bus.load_count == 0 || int'(bus.load_base) + int'(bus.load_count) > DEPTH) m_err = 1;
                else begin
                    m_err = 0; m_csum = 0; m_addr = int'(bus.load_base); m_rem = int'(bus.load_count);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.load_done) done_cnt++;
        chk("s_ready", bus.s_ready, m_rem > 0);
        chk("load_busy", bus.load_busy, m_rem > 0);
        chk("load_done", bus.load_done, m_done);
        chk("load_err", bus.load_err, m_err);
        chk("load_csum", bus.load_csum, m_csum);
        chk("weight_valid", bus.weight_valid, m_wvalid);
        if (m_wknown) chk("weight_data", $unsigned(bus.weight_data), m_wdata);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int base, input int cnt);
        bus.load_start = 1;
        bus.load_base  = ADDR_W'(base);
        bus.load_count = (ADDR_W+1)'(cnt);
        cyc();
        bus.load_start = 0;
    endtask

    task automatic rd(input int addr, input int exp, input string n);
        bus.weight_rd_en = 1;
        bus.weight_addr  = ADDR_W'(addr);
        cyc();
        chk({n, "_valid"}, bus.weight_valid, 1);
        chk(n, bus.weight_data, exp);
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_s_ready"}, bus.s_ready, 0);
        chk({n, "_busy"}, bus.load_busy, 0);
        chk({n, "_done"}, bus.load_done, 0);
        chk({n, "_err"}, bus.load_err, 0);
        chk({n, "_csum"}, bus.load_csum, 0);
        chk({n, "_wdata"}, bus.weight_data, 0);
        chk({n, "_wvalid"}, bus.weight_valid, 0);
    endtask

    initial begin
        int d0;
        logic [7:0] part [4];
        int part_exp [5];
        part = '{8'h7F, 8'h80, 8'h01, 8'h02};
        part_exp = '{127, -128, 1, 2, 4};
        rst_n = 0;
        bus.load_start = 0; bus.load_base = 0; bus.load_count = 0;
        bus.s_data = 0; bus.s_valid = 0; bus.weight_rd_en = 0; bus.weight_addr = 0;
        cyc();
        chk_reset("por");
        cyc();
        rst_n = 1;
        cyc();

        start(0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            bus.s_valid = 1; bus.s_data = 8'(i); cyc();
        end
        bus.s_valid = 0;
        chk("full_done", bus.load_done, 1);
        // 64 ramps of 0..255 sum to 0x1FE000, which truncates to 0xE000
        chk("full_csum", bus.load_csum, 16'hE000);

        rd(16'h0000, 0, "rd_0000");
        rd(16'h00FF, -1, "rd_00ff");
        rd(16'h3FFF, -1, "rd_3fff");
        bus.weight_rd_en = 0;
        cyc();
        chk("rd_idle_valid", bus.weight_valid, 0);
        chk("rd_idle_hold", bus.weight_data, -1);

        start(16'h100, 4);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                bus.s_valid = 0;
                repeat (3) cyc();
            end
            bus.s_valid = 1; bus.s_data = part[k]; cyc();
        end
        bus.s_valid = 0;
        chk("part_done", bus.load_done, 1);
        chk("part_csum", bus.load_csum, 16'h0102);
        for (int k = 0; k < 5; k++) rd(16'h100 + k, part_exp[k], "part_rb");
        bus.weight_rd_en = 0;

        start(16'h3FFF, 2);
        chk("rej_wrap_err", bus.load_err, 1);
        chk("rej_wrap_rdy", bus.s_ready, 0);
        start(16'h3FFF, 0);
        chk("rej_zero_err", bus.load_err, 1);
        chk("rej_zero_rdy", bus.s_ready, 0);
        start(0, DEPTH + 1);
        chk("rej_big_err", bus.load_err, 1);
        rd(16'h3FFF, -1, "rej_mem");
        rd(16'h0000, 0, "rej_mem0");
        bus.weight_rd_en = 0;
        start(16'h200, 1);
        chk("ok_clears_err", bus.load_err, 0);
        chk("ok_ready", bus.s_ready, 1);
        bus.s_valid = 1; bus.s_data = 8'h33; cyc();
        bus.s_valid = 0; cyc();

        d0 = done_cnt;
        start(16'h300, 6);
        bus.weight_rd_en = 1; bus.weight_addr = 16'h300;
        for (int k = 0; k < 6; k++) begin
            bus.s_valid = 1; bus.s_data = 8'(8'h10 + k);
            if (k == 2) begin bus.load_start = 1; bus.load_base = 0; bus.load_count = 1; end
            cyc();
            bus.load_start = 0;
            chk("rdload_valid", bus.weight_valid, 0);
        end
        bus.s_valid = 0;
        cyc();
        chk("rdload_done_read", bus.weight_valid, 1);
        chk("rdload_data", bus.weight_data, 8'h10);
        bus.weight_rd_en = 0;
        repeat (3) cyc();
        chk("rdload_single_done", done_cnt - d0, 1);

        start(16'h400, 8);
        bus.s_valid = 1; bus.s_data = 8'hA5; cyc();
        bus.s_data = 8'h5A; cyc();
        bus.s_data = 8'h77;
        d0 = done_cnt;
        rst_n = 0;
        #1;
        chk_reset("midrst");
        bus.s_valid = 0;
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        rd(16'h400, -91, "rst_rb0");
        rd(16'h401, 8'h5A, "rst_rb1");
        rd(16'h402, 8'h02, "rst_rb2");
        bus.weight_rd_en = 0;
        repeat (2) cyc();
        chk("rst_no_done", done_cnt - d0, 0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                int base, cnt;
                base = $urandom_range(0, 3) == 0 ? DEPTH - int'($urandom_range(1, 6)) : int'($urandom_range(0, DEPTH - 1));
                cnt  = $urandom_range(0, 12);
                bus.weight_rd_en = 1'($urandom_range(0, 1));
                bus.weight_addr  = ADDR_W'($urandom);
                start(base, cnt);
                if (m_rem > 0) begin
                    for (int k = 0; k < cnt; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            bus.s_valid = 0; bus.weight_rd_en = 1'($urandom_range(0, 1)); cyc();
                        end
                        bus.s_valid = 1; bus.s_data = 8'($urandom); cyc();
                    end
                end
                bus.s_valid = 0; bus.weight_rd_en = 0;
                cyc();
            end else begin
                repeat (5) begin
                    bus.weight_rd_en = 1'($urandom_range(0, 1));
                    bus.weight_addr  = ADDR_W'($urandom);
                    bus.s_valid = 1'($urandom_range(0, 1)); bus.s_data = 8'($urandom);
                    cyc();
                end
                bus.weight_rd_en = 0; bus.s_valid = 0;
            end
        end
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
